// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: arbiter states and cache-line geometry shared across the pipeline
package mem_arbiter_pkg;
  localparam int DEF_LINE_WORDS = 4;
  localparam int BYTE_OFF_W = 2;
  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D, DONE} arbState_t;
  function automatic int lineOffW(input int lineWords);
    return $clog2(lineWords) + BYTE_OFF_W;
  endfunction
endpackage

// File: rtl/mem_arbiter_line_counter.sv
// line_counter: word offset within a line fill; wraps at the line end and flags the last word
module line_counter
  import mem_arbiter_pkg::*;
#(
  parameter int LINE_WORDS = DEF_LINE_WORDS
) (
  input  logic                          CLK,
  input  logic                          reset,
  input  logic                          clr,
  input  logic                          inc,
  output logic [$clog2(LINE_WORDS)-1:0] cnt,
  output logic                          last
);
  always_ff @(posedge CLK or posedge reset)
    if (reset) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc) cnt <= cnt + 1'b1;
  // power-of-two line: all-ones is the final word and the increment wraps to 0
  assign last = &cnt;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between I-cache fills and D-cache fills/writes,
// D side first; one transaction at a time with a single DONE cycle between grants.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LINE_WORDS = DEF_LINE_WORDS
) (
  input  logic                          CLK,
  input  logic                          reset,
  input  logic                          IReq,
  input  logic [ADDR_W-1:0]             IAddr,
  output logic [DATA_W-1:0]             IRdata,
  output logic                          IValid,
  output logic [$clog2(LINE_WORDS)-1:0] IWordIdx,
  output logic                          IDone,
  input  logic                          DReq,
  input  logic                          DWe,
  input  logic [ADDR_W-1:0]             DAddr,
  input  logic [DATA_W-1:0]             DWdata,
  output logic [DATA_W-1:0]             DRdata,
  output logic                          DValid,
  output logic [$clog2(LINE_WORDS)-1:0] DWordIdx,
  output logic                          DDone,
  output logic                          MemReq,
  output logic                          MemWe,
  output logic [ADDR_W-1:0]             MemAddr,
  output logic [DATA_W-1:0]             MemWdata,
  input  logic [DATA_W-1:0]             MemRdata,
  input  logic                          MemAck,
  output logic                          Busy
);
  localparam int IDX_W = $clog2(LINE_WORDS);
  localparam int OFF_W = lineOffW(LINE_WORDS);
  arbState_t state;
  logic [ADDR_W-OFF_W-1:0] baseQ;
  logic weQ;
  logic [DATA_W-1:0] wdataQ;
  logic [IDX_W-1:0] cnt;
  logic last;
  logic unusedOffset;
  assign unusedOffset = &{1'b0, IAddr[OFF_W-1:0], DAddr[OFF_W-1:0]};
  assign MemReq = (state == GNT_I) || (state == GNT_D);
  assign MemWe = (state == GNT_D) && weQ;
  assign MemAddr = MemReq ? {baseQ, cnt, {BYTE_OFF_W{1'b0}}} : '0;
  assign MemWdata = MemWe ? wdataQ : '0;
  assign Busy = state != IDLE;
  line_counter #(.LINE_WORDS(LINE_WORDS)) uCnt (
    .CLK  (CLK),
    .reset(reset),
    .clr  (state == IDLE),
    .inc  (MemReq && MemAck),
    .cnt  (cnt),
    .last (last)
  );
  always_ff @(posedge CLK or posedge reset)
    if (reset) begin
      state <= IDLE;
      baseQ <= '0;
      weQ <= 1'b0;
      wdataQ <= '0;
      IRdata <= '0;
      IValid <= 1'b0;
      IWordIdx <= '0;
      IDone <= 1'b0;
      DRdata <= '0;
      DValid <= 1'b0;
      DWordIdx <= '0;
      DDone <= 1'b0;
    end else begin
      IValid <= 1'b0;
      IDone <= 1'b0;
      DValid <= 1'b0;
      DDone <= 1'b0;
      case (state)
        IDLE: if (DReq || IReq) begin
          state <= DReq ? GNT_D : GNT_I;
          baseQ <= DReq ? DAddr[ADDR_W-1:OFF_W] : IAddr[ADDR_W-1:OFF_W];
          weQ <= DReq && DWe;
          wdataQ <= DWdata;
        end
        GNT_I: if (MemAck) begin
          IRdata <= MemRdata;
          IValid <= 1'b1;
          IWordIdx <= cnt;
          if (last) begin
            state <= DONE;
            IDone <= 1'b1;
          end
        end
        GNT_D: if (MemAck) begin
          DWordIdx <= cnt;
          if (!weQ) begin
            DRdata <= MemRdata;
            DValid <= 1'b1;
          end
          if (weQ || last) begin
            state <= DONE;
            DDone <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of arbitration, fills, writes, DONE gap and reset abort
module tb_mem_arbiter;
  logic CLK = 1'b0;
  logic reset = 1'b1;
  logic IReq = 1'b0, DReq = 1'b0, DWe = 1'b0, MemAck = 1'b0;
  logic [31:0] IAddr = '0, DAddr = '0, DWdata = '0, MemRdata = '0;
  logic [31:0] IRdata, DRdata, MemAddr, MemWdata;
  logic IValid, IDone, DValid, DDone, MemReq, MemWe, Busy;
  logic [1:0] IWordIdx, DWordIdx;
  int checks = 0;
  int errors = 0;
  always #5 CLK = ~CLK;
  mem_arbiter dut (
    .CLK(CLK), .reset(reset),
    .IReq(IReq), .IAddr(IAddr), .IRdata(IRdata), .IValid(IValid), .IWordIdx(IWordIdx), .IDone(IDone),
    .DReq(DReq), .DWe(DWe), .DAddr(DAddr), .DWdata(DWdata), .DRdata(DRdata), .DValid(DValid),
    .DWordIdx(DWordIdx), .DDone(DDone),
    .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr), .MemWdata(MemWdata),
    .MemRdata(MemRdata), .MemAck(MemAck), .Busy(Busy)
  );
  task automatic cyc;
    @(posedge CLK);
    #2;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic allZero(input string tag);
    chk({tag, "_memreq"}, MemReq, 0);
    chk({tag, "_memwe"}, MemWe, 0);
    chk({tag, "_memaddr"}, MemAddr, 0);
    chk({tag, "_memwdata"}, MemWdata, 0);
    chk({tag, "_irdata"}, IRdata, 0);
    chk({tag, "_ivalid"}, IValid, 0);
    chk({tag, "_iidx"}, IWordIdx, 0);
    chk({tag, "_idone"}, IDone, 0);
    chk({tag, "_drdata"}, DRdata, 0);
    chk({tag, "_dvalid"}, DValid, 0);
    chk({tag, "_didx"}, DWordIdx, 0);
    chk({tag, "_ddone"}, DDone, 0);
    chk({tag, "_busy"}, Busy, 0);
  endtask
  initial begin
    cyc;
    cyc;
    allZero("rst");
    reset = 1'b0;
    IReq = 1'b1;
    IAddr = 32'h0000_1234;
    MemAck = 1'b1;
    chk("a_idle_busy", Busy, 0);
    cyc;
    chk("a_memreq", MemReq, 1);
    chk("a_busy", Busy, 1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("a_addr%0d", i), MemAddr, 32'h1230 + 4 * i);
      MemRdata = 32'hA0 + i;
      cyc;
      chk($sformatf("a_ivalid%0d", i), IValid, 1);
      chk($sformatf("a_iidx%0d", i), IWordIdx, i);
      chk($sformatf("a_irdata%0d", i), IRdata, 32'hA0 + i);
      chk($sformatf("a_idone%0d", i), IDone, i == 3);
      chk($sformatf("a_dvalid%0d", i), DValid, 0);
    end
    chk("a_done_busy", Busy, 1);
    chk("a_done_memreq", MemReq, 0);
    cyc;
    chk("f_no_regrant", Busy, 0);
    chk("f_idone_once", IDone, 0);
    chk("f_ivalid_off", IValid, 0);
    IReq = 1'b0;
    cyc;
    chk("g_idle_ack_ivalid", IValid, 0);
    chk("g_idle_ack_busy", Busy, 0);
    IReq = 1'b1;
    IAddr = 32'h0000_0100;
    DReq = 1'b1;
    DWe = 1'b0;
    DAddr = 32'h0000_0040;
    cyc;
    chk("c_dgrant_memreq", MemReq, 1);
    chk("c_dgrant_memwe", MemWe, 0);
    DReq = 1'b0;
    DAddr = 32'h0000_0999;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("c_addr%0d", i), MemAddr, 32'h40 + 4 * i);
      MemRdata = 32'hD0 + i;
      cyc;
      chk($sformatf("c_dvalid%0d", i), DValid, 1);
      chk($sformatf("c_didx%0d", i), DWordIdx, i);
      chk($sformatf("c_drdata%0d", i), DRdata, 32'hD0 + i);
      chk($sformatf("c_ddone%0d", i), DDone, i == 3);
      chk($sformatf("c_ivalid%0d", i), IValid, 0);
      chk($sformatf("c_idone%0d", i), IDone, 0);
    end
    MemAck = 1'b0;
    cyc;
    chk("c_gap_busy", Busy, 0);
    chk("c_gap_memreq", MemReq, 0);
    cyc;
    chk("c_igrant_memreq", MemReq, 1);
    chk("c_igrant_addr", MemAddr, 32'h100);
    MemAck = 1'b1;
    repeat (4) cyc;
    chk("c_i_done", IDone, 1);
    chk("c_i_lastidx", IWordIdx, 3);
    IReq = 1'b0;
    MemAck = 1'b0;
    cyc;
    DReq = 1'b1;
    DWe = 1'b1;
    DAddr = 32'h0000_0080;
    DWdata = 32'hDEAD_BEEF;
    cyc;
    chk("d_memreq", MemReq, 1);
    chk("d_memwe", MemWe, 1);
    chk("d_memaddr", MemAddr, 32'h80);
    chk("d_memwdata", MemWdata, 32'hDEAD_BEEF);
    DReq = 1'b0;
    DWe = 1'b0;
    DWdata = 32'h0000_1111;
    for (int i = 0; i < 2; i++) begin
      cyc;
      chk($sformatf("d_wait_memwe%0d", i), MemWe, 1);
      chk($sformatf("d_wait_wdata%0d", i), MemWdata, 32'hDEAD_BEEF);
      chk($sformatf("d_wait_dvalid%0d", i), DValid, 0);
    end
    MemAck = 1'b1;
    cyc;
    chk("d_ddone", DDone, 1);
    chk("d_dvalid", DValid, 0);
    chk("d_done_memreq", MemReq, 0);
    MemAck = 1'b0;
    cyc;
    chk("d_ddone_off", DDone, 0);
    chk("d_idle_busy", Busy, 0);
    IReq = 1'b1;
    IAddr = 32'h0000_2000;
    MemAck = 1'b1;
    cyc;
    cyc;
    cyc;
    chk("e_mid_idx", IWordIdx, 1);
    chk("e_mid_valid", IValid, 1);
    reset = 1'b1;
    #1;
    allZero("e_rst");
    cyc;
    allZero("e_rst_hold");
    reset = 1'b0;
    MemAck = 1'b0;
    cyc;
    chk("e_restart_memreq", MemReq, 1);
    chk("e_restart_addr", MemAddr, 32'h2000);
    MemRdata = 32'h55;
    MemAck = 1'b1;
    cyc;
    chk("e_restart_idx", IWordIdx, 0);
    chk("e_restart_valid", IValid, 1);
    chk("e_restart_rdata", IRdata, 32'h55);
    IReq = 1'b0;
    MemAck = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, byte-address width.
REQ-002 Parameter DATA_W, default 32, word width.
REQ-003 Parameter LINE_WORDS, default 4, words per cache-line fill; power of two, at least 2.
REQ-004 CLK  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 IReq  input  1  I-cache line-fill request; held high until IDone.
REQ-007 IAddr  input  ADDR_W  I-side miss address; low log2(LINE_WORDS)+2 bits ignored.
REQ-008 IRdata  output  DATA_W  fill word to I-cache.
REQ-009 IValid  output  1  IRdata valid this cycle.
REQ-010 IWordIdx  output  log2(LINE_WORDS)  line offset of IRdata.
REQ-011 IDone  output  1  one-cycle pulse: I transaction complete.
REQ-012 DReq, DWe  input  1 each  D-cache request; DWe=1 is a single-word write, DWe=0 is a line fill.
REQ-013 DAddr  input  ADDR_W  D-side address; DWdata  input  DATA_W  write data.
REQ-014 DRdata  output  DATA_W; DValid  output  1; DWordIdx  output  log2(LINE_WORDS); DDone  output  1; same meaning as the I-side signals.
REQ-015 MemReq  output  1; MemWe  output  1; MemAddr  output  ADDR_W; MemWdata  output  DATA_W  shared main-memory port.
REQ-016 MemRdata  input  DATA_W; MemAck  input  1  memory completes one word per MemAck cycle, after arbitrary latency.
REQ-017 Busy  output  1  high in any state other than IDLE; feeds the hazard unit's CacheReady as its inverse.

Function
REQ-018 The FSM SHALL have exactly four states: IDLE, GNT_I, GNT_D and DONE.
REQ-019 In IDLE, DReq=1 SHALL cause a transition to GNT_D, regardless of IReq.
REQ-020 In IDLE, IReq=1 with DReq=0 SHALL cause a transition to GNT_I; the D side has fixed priority as the older instruction.
REQ-021 On grant, the address with its offset cleared, DWe and DWdata SHALL be latched; the word counter SHALL be cleared.
REQ-022 In GNT states, MemReq=1 and MemAddr={latched line base, counter, 2'b00}; MemWe=1 only for D writes.
REQ-023 Each MemAck in a GNT state SHALL register MemRdata to the granted side's Rdata, pulse its Valid for 1 cycle, drive WordIdx=counter and increment the counter.
REQ-024 Valid SHALL appear 1 cycle after the MemAck.
REQ-025 A write SHALL complete on its first MemAck and SHALL not assert DValid.
REQ-026 A fill SHALL complete on the ack with counter=LINE_WORDS-1; the counter wraps to 0 at that ack.
REQ-027 On completion, the FSM SHALL enter DONE for exactly 1 cycle, pulsing the granted side's Done together with the final Valid, then return to IDLE.
REQ-028 Requests SHALL be ignored in DONE, so a still-high Req is not regranted; arbitration resumes in IDLE on the following cycle.
REQ-029 MemAck SHALL be ignored in IDLE and DONE.
REQ-030 Request deassertion during GNT SHALL NOT abort the transfer; the transaction completes.
REQ-031 Request inputs SHALL be sampled only in IDLE; address or data changes in other states have no effect.
REQ-032 The non-granted side's Valid and Done SHALL stay 0.

Reset
REQ-033 While reset is asserted, the FSM SHALL be held in IDLE and the counter at 0.
REQ-034 While reset is asserted, all outputs SHALL be 0: MemReq, MemWe, MemAddr, MemWdata, every Valid, Done and data output, and Busy.
REQ-035 Reset mid-transaction SHALL discard the transfer with no Done pulse.

Structure
REQ-036 The state enum and LINE_WORDS/offset-width constants SHALL reside in the shared pipeline package.
REQ-037 The word counter SHALL be one sub-module, line_counter: clear, increment, wrap and last flag.

Verification
REQ-038 IReq=1, IAddr=0x0000_1234, MemAck every cycle: MemAddr sequences 0x1230, 0x1234, 0x1238, 0x123C; four IValid with IWordIdx 0..3; IDone on the 4th; Busy low 1 cycle later.
REQ-039 IReq and DReq (DWe=0, DAddr=0x40) rise in the same cycle: D fill runs first; I is granted 2 cycles after DDone (DONE, then IDLE).
REQ-040 DReq=1, DWe=1, DAddr=0x80, DWdata=0xDEADBEEF, MemAck after 3 cycles: MemWe=1 with that address and data; DDone pulses; DValid never asserted.
REQ-041 Requester holds IReq high 2 cycles past IDone: no second grant occurs while in DONE.
REQ-042 Reset asserted after 2 of 4 acks: all outputs 0 immediately, no Done; a new IReq restarts at offset 0.
REQ-043 MemAck pulsed while in IDLE: no Valid and no state change.
